// File: rtl/register_scoreboard_pkg.sv
// register_scoreboard_pkg: shared register-file types for the issue scoreboard
package register_scoreboard_pkg;
   localparam int XLEN = 32;
   typedef logic [4:0] rv_reg_t;
   typedef struct packed {
      logic    valid;
      rv_reg_t rd;
   } scoreboard_entry_t;
endpackage

// File: rtl/register_scoreboard_if.sv
// register_scoreboard_if: decode/writeback/flush bundle seen by the scoreboard
interface register_scoreboard_if
   import register_scoreboard_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   logic             issue_valid;
   rv_reg_t          issue_rs1;
   logic             issue_rs1_used;
   rv_reg_t          issue_rs2;
   logic             issue_rs2_used;
   rv_reg_t          issue_rd;
   logic             issue_rd_write;
   logic             issue_ready;
   logic             retire_valid;
   rv_reg_t          retire_rd;
   logic             flush_valid;
   logic [CNT_W-1:0] flush_keep;
   logic [CNT_W-1:0] inflight_count;
   logic [XLEN-1:0]  stall_cycles;
   logic             protocol_error;
   modport master (
      output issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
             issue_rd, issue_rd_write, retire_valid, retire_rd, flush_valid, flush_keep,
      input  issue_ready, inflight_count, stall_cycles, protocol_error
   );
   modport slave (
      input  issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
             issue_rd, issue_rd_write, retire_valid, retire_rd, flush_valid, flush_keep,
      output issue_ready, inflight_count, stall_cycles, protocol_error
   );
endinterface

// File: rtl/register_scoreboard_tag_fifo.sv
// scoreboard_tag_fifo: in-order circular buffer of pending rd writes with pop-then-truncate
module scoreboard_tag_fifo
   import register_scoreboard_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1),
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           push_i,
   input  rv_reg_t                        push_rd_i,
   input  logic                           pop_i,
   input  logic                           trunc_i,
   input  logic [CNT_W-1:0]               trunc_keep_i,
   output scoreboard_entry_t [DEPTH-1:0]  entries_o,
   output rv_reg_t                        head_rd_o,
   output logic [CNT_W-1:0]               count_o
);
   logic [PTR_W-1:0] head_q, head_d, tail;
   logic [CNT_W-1:0] count_q, count_d, remain;
   rv_reg_t          rd_q [DEPTH];

   function automatic logic [PTR_W-1:0] wrap(input int v);
      return PTR_W'(v % DEPTH);
   endfunction

   // truncation acts on what is left after the same-cycle pop
   always_comb begin
      remain  = count_q - CNT_W'(pop_i);
      head_d  = pop_i ? wrap(int'(head_q) + 1) : head_q;
      tail    = wrap(int'(head_q) + int'(count_q));
      count_d = trunc_i ? ((trunc_keep_i < remain) ? trunc_keep_i : remain)
                        : remain + CNT_W'(push_i);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         count_q <= count_d;
      end
      if (push_i && !trunc_i && !reset) rd_q[tail] <= push_rd_i;
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      assign entries_o[e].valid = ((e + DEPTH - int'(head_q)) % DEPTH) < int'(count_q);
      assign entries_o[e].rd    = rd_q[e];
   end

   assign head_rd_o = rd_q[head_q];
   assign count_o   = count_q;
endmodule

// File: rtl/register_scoreboard.sv
// register_scoreboard: RAW-hazard issue gate over the in-flight writer FIFO,
// with a saturating stall counter and a sticky protocol-error flag.
module register_scoreboard
   import register_scoreboard_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input logic                  clock,
   input logic                  reset,
   register_scoreboard_if.slave sb
);
   scoreboard_entry_t [DEPTH-1:0] entries;
   rv_reg_t                       head_rd;
   logic [CNT_W-1:0]              count;
   logic                          haz1, haz2, tracked, full, ready, pop;
   logic                          err_q, err_d;
   logic [XLEN-1:0]               stall_q, stall_d;

   // the retiring head still hazards: reads are registered with no bypass
   always_comb begin
      haz1 = 1'b0;
      haz2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         haz1 = haz1 | (entries[i].valid && entries[i].rd == sb.issue_rs1);
         haz2 = haz2 | (entries[i].valid && entries[i].rd == sb.issue_rs2);
      end
      haz1 = haz1 && sb.issue_rs1_used && sb.issue_rs1 != '0;
      haz2 = haz2 && sb.issue_rs2_used && sb.issue_rs2 != '0;
   end

   assign tracked = sb.issue_rd_write && sb.issue_rd != '0;
   assign full    = count == CNT_W'(DEPTH);
   assign ready   = !sb.flush_valid && !haz1 && !haz2 && !(tracked && full);
   assign pop     = sb.retire_valid && count != '0;
   assign err_d   = err_q | (sb.retire_valid && (count == '0 || sb.retire_rd != head_rd));
   assign stall_d = (sb.issue_valid && !ready && stall_q != '1) ? stall_q + XLEN'(1) : stall_q;

   scoreboard_tag_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .push_i       (sb.issue_valid && ready && tracked),
      .push_rd_i    (sb.issue_rd),
      .pop_i        (pop),
      .trunc_i      (sb.flush_valid),
      .trunc_keep_i (sb.flush_keep),
      .entries_o    (entries),
      .head_rd_o    (head_rd),
      .count_o      (count)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         err_q   <= 1'b0;
         stall_q <= '0;
      end else begin
         err_q   <= err_d;
         stall_q <= stall_d;
      end
   end

   assign sb.issue_ready    = ready;
   assign sb.inflight_count = count;
   assign sb.stall_cycles   = stall_q;
   assign sb.protocol_error = err_q;
endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
In-order RAW-hazard scheduler in front of the 32-entry register file.
- Decode presents an instruction's source and destination registers. The scoreboard holds it back while any older in-flight instruction still owes a write to one of its sources.
- Tracks in-flight writers in a small in-order tag FIFO: pushed at issue, popped at writeback, truncated on pipeline flush.
- Register-file reads are registered and have no write-to-read bypass, so a write retiring this cycle does not clear a hazard until the next cycle.

Parameters:
DEPTH, 4, maximum in-flight instructions with a pending rd write (≥2)
CNT_W, $clog2(DEPTH+1), width of occupancy and flush_keep fields

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
issue_valid  input  1  decode has an instruction ready to issue
issue_rs1  input  rv_reg_t(5)  source register 1
issue_rs1_used  input  1  instruction reads rs1
issue_rs2  input  rv_reg_t(5)  source register 2
issue_rs2_used  input  1  instruction reads rs2
issue_rd  input  rv_reg_t(5)  destination register
issue_rd_write  input  1  instruction writes rd
issue_ready  output  1  issue permitted this cycle (combinational)
retire_valid  input  1  writeback commits the oldest tracked write this cycle
retire_rd  input  rv_reg_t(5)  register being written back
flush_valid  input  1  pipeline squash
flush_keep  input  CNT_W  number of oldest tracked entries that survive the flush
inflight_count  output  CNT_W  current FIFO occupancy (registered)
stall_cycles  output  32  saturating count of cycles with issue_valid=1 and issue_ready=0
protocol_error  output  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: clock clock; reset reset, synchronous, active-high.
- Reset values: FIFO empty, inflight_count=0, stall_cycles=0, protocol_error=0. Reset mid-operation discards all entries; a retire or flush in the reset cycle is ignored.
- Tracked instruction: issue_rd_write=1 and issue_rd≠0. Writes to x0 and non-writing instructions are never enqueued. Retire and flush_keep count only tracked instructions.
- Hazard, combinational: a source hazards if its used bit is 1, the register is ≠0, and it equals the rd of any valid entry. The head entry still hazards in the cycle it retires.
- issue_ready = !flush_valid && !hazard(rs1) && !hazard(rs2) && !(tracked && inflight_count==DEPTH).
  - Full stalls even when a retire occurs in the same cycle.
  - issue_ready is meaningful regardless of issue_valid.
- issue_fire = issue_valid && issue_ready. A tracked fire pushes issue_rd at the tail next edge.
- Retire: pops the head.
  - retire_rd ≠ head rd: set protocol_error; still pop.
  - Retire while empty: set protocol_error; no state change.
- Simultaneous issue+retire: push and pop in the same edge; occupancy unchanged.
- Flush:
  - Retire is applied first.
  - The remaining entries are truncated to the oldest min(flush_keep, remaining); no error on clamp.
  - An issue in the same cycle is blocked (issue_ready=0), so nothing is pushed.
- Pointers: head/tail wrap modulo DEPTH. Occupancy is an explicit counter, so full and empty are unambiguous.
- stall_cycles saturates at 0xFFFFFFFF and does not wrap. It counts flush-blocked cycles too.
- protocol_error clears only on reset.

Decomposition:
- Shared package: rv_reg_t, XLEN, and a new scoreboard_entry_t {logic valid; rv_reg_t rd}.
- Sub-module scoreboard_tag_fifo: circular buffer with push, pop, truncate-to-N and per-entry valid/rd outputs.
- register_scoreboard itself holds the hazard comparators, ready logic, error and stall counter.

Test Plan:
- Issue rd=x5; next cycle issue rs1=x5 used → issue_ready=0. Retire x5 → still 0 that cycle, 1 the cycle after; stall_cycles=2.
- rs2=x0 used while x0 issued as rd → no entry enqueued, issue_ready=1, inflight_count unchanged.
- DEPTH=4: issue rd=x1..x4 → inflight_count=4. Independent writer rd=x6 → ready=0 even with a same-cycle retire. Non-writer with rs1=x7 → ready=1.
- Entries x1,x2,x3: flush_valid with flush_keep=1 and retire x1 same cycle → only x2 remains, inflight_count=1, issue blocked that cycle.
- Retire x9 while head is x3 → protocol_error=1, head popped. Retire while empty → stays 1, inflight_count=0. Reset → 0.
- Preload stall_cycles near 0xFFFFFFFF (force), hold a hazard 5 cycles → saturates at 0xFFFFFFFF.
